// File: rtl/branch_resolve_if.sv
// Fetch-prediction, pipeline-control and EX-resolution signals shared between
// the pipeline (master) and the branch_resolve stage (slave).
interface branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      CurrentPC;
  logic             BTBhit;
  logic [31:0]      PrePC;
  logic             PredTakenF;
  logic [31:0]      PredPCF;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic             BranchE;
  logic             BrTakenE;
  logic [31:0]      BrNPC;
  logic [31:0]      EXpc;
  logic [1:0]       BTBflush;
  logic             RedirectE;
  logic [31:0]      RedirectPC;
  logic [CNT_W-1:0] BrCount;
  logic [CNT_W-1:0] MissCount;

  modport master (
    output CurrentPC, BTBhit, PrePC, StallD, FlushD, StallE, FlushE,
           BranchE, BrTakenE, BrNPC,
    input  PredTakenF, PredPCF, EXpc, BTBflush, RedirectE, RedirectPC,
           BrCount, MissCount
  );

  modport slave (
    input  CurrentPC, BTBhit, PrePC, StallD, FlushD, StallE, FlushE,
           BranchE, BrTakenE, BrNPC,
    output PredTakenF, PredPCF, EXpc, BTBflush, RedirectE, RedirectPC,
           BrCount, MissCount
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch prediction companion to the BTB: 2-bit BHT lookup in IF, metadata
// pipelined through ID/EX, resolution, BTB update code and miss statistics in EX.
module branch_resolve #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus
);
  localparam int BHT_N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]       bht_r [BHT_N];
  logic             valid_d_r, pt_d_r, valid_e_r, pt_e_r;
  logic [31:0]      pc_d_r, ppc_d_r, pc_e_r, ppc_e_r;
  logic [CNT_W-1:0] br_cnt_r, miss_cnt_r;

  logic [IDX_W-1:0] idx_f_s, idx_e_s;
  logic             pt_f_s, redirect_s;
  logic [31:0]      ppc_f_s, rpc_s, pc_e_plus4_s;
  logic [1:0]       flush_s, cnt_upd_s;

  // IF prediction: BTB hit qualified by the BHT direction bit
  always_comb begin
    idx_f_s = bus.CurrentPC[IDX_W+1:2];
    pt_f_s  = bus.BTBhit & bht_r[idx_f_s][1];
    if (pt_f_s) begin
      ppc_f_s = bus.PrePC;
    end else begin
      ppc_f_s = bus.CurrentPC + 32'd4;
    end
  end

  // IF/ID metadata register; flush wins over stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d_r <= 1'b0;
      pt_d_r    <= 1'b0;
      pc_d_r    <= 32'd0;
      ppc_d_r   <= 32'd0;
    end else if (bus.FlushD) begin
      valid_d_r <= 1'b0;
      pt_d_r    <= 1'b0;
    end else if (!bus.StallD) begin
      valid_d_r <= 1'b1;
      pt_d_r    <= pt_f_s;
      pc_d_r    <= bus.CurrentPC;
      ppc_d_r   <= ppc_f_s;
    end
  end

  // ID/EX metadata register; flush wins over stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e_r <= 1'b0;
      pt_e_r    <= 1'b0;
      pc_e_r    <= 32'd0;
      ppc_e_r   <= 32'd0;
    end else if (bus.FlushE) begin
      valid_e_r <= 1'b0;
      pt_e_r    <= 1'b0;
    end else if (!bus.StallE) begin
      valid_e_r <= valid_d_r;
      pt_e_r    <= pt_d_r;
      pc_e_r    <= pc_d_r;
      ppc_e_r   <= ppc_d_r;
    end
  end

  // EX resolution: a stalled EX never raises a redirect, so the BTB sees one write per instruction
  always_comb begin
    idx_e_s      = pc_e_r[IDX_W+1:2];
    pc_e_plus4_s = pc_e_r + 32'd4;
    cnt_upd_s    = sat_update(bht_r[idx_e_s], bus.BrTakenE);
    redirect_s   = 1'b0;
    rpc_s        = 32'd0;
    flush_s      = 2'b00;
    if (valid_e_r && !bus.StallE) begin
      case ({pt_e_r, bus.BranchE, bus.BrTakenE})
        3'b111: begin
          if (ppc_e_r != bus.BrNPC) begin
            redirect_s = 1'b1;
            rpc_s      = bus.BrNPC;
            flush_s    = 2'b10;
          end else begin
            redirect_s = 1'b0;
          end
        end
        3'b011: begin
          redirect_s = 1'b1;
          rpc_s      = bus.BrNPC;
          flush_s    = 2'b10;
        end
        3'b110: begin
          redirect_s = 1'b1;
          rpc_s      = pc_e_plus4_s;
          flush_s    = (cnt_upd_s == 2'b00) ? 2'b01 : 2'b00;
        end
        3'b100, 3'b101: begin
          redirect_s = 1'b1;
          rpc_s      = pc_e_plus4_s;
          flush_s    = 2'b01;
        end
        default: begin
          redirect_s = 1'b0;
        end
      endcase
    end else begin
      redirect_s = 1'b0;
    end
  end

  // BHT training on resolved conditional branches; IF reads the pre-update value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (valid_e_r && bus.BranchE && !bus.StallE) begin
      bht_r[idx_e_s] <= cnt_upd_s;
    end
  end

  // Saturating branch and redirect statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_r   <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else if (valid_e_r && !bus.StallE) begin
      if (bus.BranchE && (br_cnt_r != CNT_MAX)) begin
        br_cnt_r <= br_cnt_r + CNT_ONE;
      end
      if (redirect_s && (miss_cnt_r != CNT_MAX)) begin
        miss_cnt_r <= miss_cnt_r + CNT_ONE;
      end
    end
  end

  assign bus.PredTakenF = pt_f_s;
  assign bus.PredPCF    = ppc_f_s;
  assign bus.EXpc       = pc_e_r;
  assign bus.RedirectE  = redirect_s;
  assign bus.RedirectPC = rpc_s;
  assign bus.BTBflush   = flush_s;
  assign bus.BrCount    = br_cnt_r;
  assign bus.MissCount  = miss_cnt_r;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: per-cycle vectors with hand-computed
// expectations go into a queue that a negedge monitor drains and compares.
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  branch_resolve_if bus();
  branch_resolve dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] prepc;
    logic [3:0]  ctl;   // {StallD, FlushD, StallE, FlushE}
    logic        br;
    logic        tk;
    logic [31:0] npc;
    logic        pt;
    logic [31:0] ppc;
    logic        rd;
    logic [31:0] rpc;
    logic [1:0]  fl;
    logic        ce;
    logic [31:0] expc;
    logic [15:0] bc;
    logic [15:0] mc;
  } vec_t;

  localparam logic [31:0] IDL  = 32'h204;
  localparam logic [31:0] IDL4 = 32'h208;
  localparam int NV = 31;

  vec_t tbl [NV];
  vec_t exp_q [$];

  function automatic vec_t mk(logic [31:0] pc, logic hit, logic [31:0] prepc, logic [3:0] ctl,
                              logic br, logic tk, logic [31:0] npc, logic pt, logic [31:0] ppc,
                              logic rd, logic [31:0] rpc, logic [1:0] fl, logic ce,
                              logic [31:0] expc, logic [15:0] bc, logic [15:0] mc);
    vec_t v;
    v = '{pc, hit, prepc, ctl, br, tk, npc, pt, ppc, rd, rpc, fl, ce, expc, bc, mc};
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.CurrentPC = v.pc;
    bus.BTBhit    = v.hit;
    bus.PrePC     = v.prepc;
    {bus.StallD, bus.FlushD, bus.StallE, bus.FlushE} = v.ctl;
    bus.BranchE   = v.br;
    bus.BrTakenE  = v.tk;
    bus.BrNPC     = v.npc;
  endtask

  // Monitor: one expected record per cycle, compared on the falling edge
  initial begin : monitor
    vec_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("PredTakenF", cyc, 32'(bus.PredTakenF), 32'(e.pt));
        chk("PredPCF",    cyc, bus.PredPCF, e.ppc);
        chk("RedirectE",  cyc, 32'(bus.RedirectE), 32'(e.rd));
        if (e.rd) chk("RedirectPC", cyc, bus.RedirectPC, e.rpc);
        chk("BTBflush",   cyc, 32'(bus.BTBflush), 32'(e.fl));
        if (e.ce) chk("EXpc", cyc, bus.EXpc, e.expc);
        chk("BrCount",    cyc, 32'(bus.BrCount), 32'(e.bc));
        chk("MissCount",  cyc, 32'(bus.MissCount), 32'(e.mc));
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // fetch-side                       ctl     EX inputs                pred            redirect/flush          EXpc        counts
    tbl[0]  = mk(32'h40, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  1'b0, 32'h0,   2'b00, 1'b1, 32'h0,   16'd0,  16'd0);
    tbl[1]  = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, 32'h0,   16'd0,  16'd0);
    tbl[2]  = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h80,  1'b0, IDL4,    1'b1, 32'h80,  2'b10, 1'b1, 32'h40,  16'd0,  16'd0);
    tbl[3]  = mk(32'h40, 1'b1, 32'h80, 4'b0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd1,  16'd1);
    tbl[4]  = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd1,  16'd1);
    tbl[5]  = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h80,  1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, 32'h40,  16'd1,  16'd1);
    tbl[6]  = mk(32'h40, 1'b1, 32'h80, 4'b0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd2,  16'd1);
    tbl[7]  = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd2,  16'd1);
    tbl[8]  = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h90,  1'b0, IDL4,    1'b1, 32'h90,  2'b10, 1'b1, 32'h40,  16'd2,  16'd1);
    tbl[9]  = mk(32'h40, 1'b1, 32'h80, 4'b0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd3,  16'd2);
    tbl[10] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd3,  16'd2);
    tbl[11] = mk(32'h40, 1'b1, 32'h80, 4'b0000, 1'b1, 1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h44,  2'b00, 1'b1, 32'h40,  16'd3,  16'd2);
    tbl[12] = mk(32'h40, 1'b1, 32'h80, 4'b0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd4,  16'd3);
    tbl[13] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b0, 32'h80,  1'b0, IDL4,    1'b1, 32'h44,  2'b00, 1'b1, 32'h40,  16'd4,  16'd3);
    tbl[14] = mk(32'h40, 1'b1, 32'h80, 4'b0000, 1'b1, 1'b0, 32'h80,  1'b0, 32'h44,  1'b1, 32'h44,  2'b01, 1'b1, 32'h40,  16'd5,  16'd4);
    tbl[15] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd6,  16'd5);
    tbl[16] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b0, 32'h80,  1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, 32'h40,  16'd6,  16'd5);
    tbl[17] = mk(32'h108,1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10c, 1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd7,  16'd5);
    tbl[18] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd7,  16'd5);
    tbl[19] = mk(32'h108,1'b1, 32'h300,4'b0000, 1'b1, 1'b1, 32'h200, 1'b0, 32'h10c, 1'b1, 32'h200, 2'b10, 1'b1, 32'h108, 16'd7,  16'd5);
    tbl[20] = mk(32'h108,1'b1, 32'h300,4'b0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd8,  16'd6);
    tbl[21] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, 32'h108, 16'd8,  16'd6);
    tbl[22] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b1, 32'h10c, 2'b01, 1'b1, 32'h108, 16'd8,  16'd6);
    tbl[23] = mk(32'h108,1'b1, 32'h300,4'b0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd8,  16'd7);
    tbl[24] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd8,  16'd7);
    tbl[25] = mk(IDL,    1'b0, 32'h0,  4'b1010, 1'b1, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, 32'h108, 16'd8,  16'd7);
    tbl[26] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b0, 32'h0,   1'b0, IDL4,    1'b1, 32'h10c, 2'b00, 1'b1, 32'h108, 16'd8,  16'd7);
    tbl[27] = mk(32'h108,1'b1, 32'h300,4'b0001, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10c, 1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd9,  16'd8);
    tbl[28] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h500, 1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b0, 32'h0,   16'd9,  16'd8);
    tbl[29] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b1, 1'b1, 32'h200, 1'b0, IDL4,    1'b1, 32'h200, 2'b10, 1'b1, 32'h108, 16'd9,  16'd8);
    tbl[30] = mk(IDL,    1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, IDL4,    1'b0, 32'h0,   2'b00, 1'b1, IDL,     16'd10, 16'd9);

    // Reset state, with a BTB hit that a weakly-not-taken BHT must not follow
    rst = 1'b0;
    drive(mk(32'h40, 1'b1, 32'h80, 4'b0101, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0,
             2'b00, 1'b0, 32'h0, 16'd0, 16'd0));
    #13;
    chk("rst_PredTakenF", -1, 32'(bus.PredTakenF), 32'd0);
    chk("rst_PredPCF",    -1, bus.PredPCF, 32'h44);
    chk("rst_RedirectE",  -1, 32'(bus.RedirectE), 32'd0);
    chk("rst_BTBflush",   -1, 32'(bus.BTBflush), 32'd0);
    chk("rst_EXpc",       -1, bus.EXpc, 32'd0);
    chk("rst_BrCount",    -1, 32'(bus.BrCount), 32'd0);
    chk("rst_MissCount",  -1, 32'(bus.MissCount), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
    end

    // BHT[2] is 10 here, so a hit at 0x108 predicts taken until reset clears it
    @(posedge clk);
    #1;
    drive(mk(32'h108, 1'b1, 32'h300, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             2'b00, 1'b0, 32'h0, 16'd0, 16'd0));
    for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
    chk("queue_drained", -1, 32'(exp_q.size()), 32'd0);
    #1;
    chk("pre_rst_PredTakenF", -1, 32'(bus.PredTakenF), 32'd1);
    chk("pre_rst_BrCount",    -1, 32'(bus.BrCount), 32'd10);

    // Asynchronous reset in the middle of the high phase
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_PredTakenF", -2, 32'(bus.PredTakenF), 32'd0);
    chk("arst_PredPCF",    -2, bus.PredPCF, 32'h10c);
    chk("arst_EXpc",       -2, bus.EXpc, 32'd0);
    chk("arst_BrCount",    -2, 32'(bus.BrCount), 32'd0);
    chk("arst_MissCount",  -2, 32'(bus.MissCount), 32'd0);
    chk("arst_RedirectE",  -2, 32'(bus.RedirectE), 32'd0);
    chk("arst_BTBflush",   -2, 32'(bus.BTBflush), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
